// File: rtl/pc_sequencer_if.sv
// Instruction-fetch request channel between the PC sequencer and imem.
//   fetch_valid : request valid (driven by the sequencer)
//   fetch_addr  : word-aligned fetch address (driven by the sequencer)
//   fetch_ready : imem accepts the request this cycle (driven by imem)
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr;

    // Sequencer side
    modport master (
        output fetch_valid,
        output fetch_addr,
        input  fetch_ready
    );

    // Instruction-memory side
    modport slave (
        input  fetch_valid,
        input  fetch_addr,
        output fetch_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch sequencer for the RISC core front end.
// Picks the next PC every cycle (trap vector > branch target > hold > PC+step),
// issues valid/ready fetch requests and flags a one-cycle flush on redirect.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : leave IDLE and begin fetching
//   stall        : decode hazard; blocks fetch and holds the PC
//   br_taken     : taken branch/jump from execute, with br_target
//   trap         : exception request, highest priority
//   fetchBus     : fetch request channel (valid/addr out, ready in)
//   pc_curr      : registered PC (also the fetch address)
//   pc_next      : combinational value pc_curr takes at the next edge
//   flush        : squash in-flight front-end instructions (registered)
//   state        : 00 IDLE, 01 FETCH, 10 HOLD, 11 FLUSH
//   fetch_count  : accepted fetches since reset, wraps at 2^16
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0100),
    parameter int unsigned       PC_STEP   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic                trap,
    pc_sequencer_if.master      fetchBus,
    output logic [ADDR_W-1:0]   pc_curr,
    output logic [ADDR_W-1:0]   pc_next,
    output logic                flush,
    output logic [1:0]          state,
    output logic [15:0]         fetch_count
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t             stateQ;
    state_t             stateD;
    logic [ADDR_W-1:0]  pcQ;
    logic [ADDR_W-1:0]  pcD;
    logic [CNT_W-1:0]   countQ;
    logic [CNT_W-1:0]   countD;
    logic               flushQ;
    logic               fetchValid;
    logic               accept;
    logic [ADDR_W-1:0]  brAligned;
    logic               unusedBrLsbs;

    // Request drops in the same cycle a stall arrives
    assign fetchValid   = (stateQ == FETCH) && !stall;
    assign accept       = fetchValid && fetchBus.fetch_ready;
    assign brAligned    = {br_target[ADDR_W-1:2], 2'b00};
    assign unusedBrLsbs = ^br_target[1:0];

    // Next-state / next-PC selection
    always_comb begin
        stateD = stateQ;
        pcD    = pcQ;
        countD = countQ;
        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    stateD = FETCH;
                end
            end
            FETCH, HOLD: begin
                if (trap) begin
                    pcD    = TRAP_VEC;
                    stateD = FLUSH;
                end else if (br_taken) begin
                    pcD    = brAligned;
                    stateD = FLUSH;
                end else if (stall) begin
                    stateD = HOLD;
                end else if (stateQ == HOLD) begin
                    stateD = FETCH;
                end else if (accept) begin
                    pcD    = pcQ + ADDR_W'(PC_STEP);
                    countD = countQ + CNT_W'(1);
                end
            end
            FLUSH: begin
                // Branches here come from the squashed path; only a trap matters
                if (trap) begin
                    pcD = TRAP_VEC;
                end else begin
                    stateD = FETCH;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // State, PC, counter and flush registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            pcQ    <= RESET_VEC;
            countQ <= '0;
            flushQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            countQ <= countD;
            flushQ <= (stateD == FLUSH);
        end
    end

    assign fetchBus.fetch_valid = fetchValid;
    assign fetchBus.fetch_addr  = pcQ;
    assign pc_curr              = pcQ;
    assign pc_next              = pcD;
    assign flush                = flushQ;
    assign state                = stateQ;
    assign fetch_count          = countQ;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations checked with
// immediate assertions at a point 1 ns after each rising edge.
module tb_pc_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic        flush;
    logic [1:0]  state;
    logic [15:0] fetch_count;

    int nVec = 0;
    int nErr = 0;

    pc_sequencer_if #(.ADDR_W(32)) fetchBus ();

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap        (trap),
        .fetchBus    (fetchBus),
        .pc_curr     (pc_curr),
        .pc_next     (pc_next),
        .flush       (flush),
        .state       (state),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state in one go
    task automatic chkAll(input string tag, input logic [1:0] expState, input logic [31:0] expPc,
                          input logic [31:0] expNext, input logic expValid, input logic expFlush,
                          input logic [15:0] expCnt);
        chk({tag, ".state"}, 32'(state), 32'(expState));
        chk({tag, ".pc_curr"}, pc_curr, expPc);
        chk({tag, ".fetch_addr"}, fetchBus.fetch_addr, expPc);
        chk({tag, ".pc_next"}, pc_next, expNext);
        chk({tag, ".fetch_valid"}, 32'(fetchBus.fetch_valid), 32'(expValid));
        chk({tag, ".flush"}, 32'(flush), 32'(expFlush));
        chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(expCnt));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        trap = 1'b0;
        fetchBus.fetch_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chkAll("reset", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        // 1: four accepted fetches 0,4,8,C
        start = 1'b1;
        fetchBus.fetch_ready = 1'b1;
        #1 chkAll("idle_start", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        tick();
        start = 1'b0;
        #1 chkAll("f0", 2'b01, 32'h0, 32'h4, 1'b1, 1'b0, 16'd0);
        tick();
        chkAll("f4", 2'b01, 32'h4, 32'h8, 1'b1, 1'b0, 16'd1);
        tick();
        chkAll("f8", 2'b01, 32'h8, 32'hC, 1'b1, 1'b0, 16'd2);
        tick();
        chkAll("fC", 2'b01, 32'hC, 32'h10, 1'b1, 1'b0, 16'd3);
        tick();

        // 2: stall three cycles at pc=0x10, then refetch 0x10
        stall = 1'b1;
        #1 chkAll("stall_comb", 2'b01, 32'h10, 32'h10, 1'b0, 1'b0, 16'd4);
        tick();
        chkAll("hold1", 2'b10, 32'h10, 32'h10, 1'b0, 1'b0, 16'd4);
        tick();
        tick();
        chkAll("hold3", 2'b10, 32'h10, 32'h10, 1'b0, 1'b0, 16'd4);
        stall = 1'b0;
        #1 chkAll("release", 2'b10, 32'h10, 32'h10, 1'b0, 1'b0, 16'd4);
        tick();

        // 3: branch to 0x203 -> 0x200, unaccepted request aborted
        fetchBus.fetch_ready = 1'b0;
        br_taken = 1'b1;
        br_target = 32'h0000_0203;
        #1 chkAll("br_req", 2'b01, 32'h10, 32'h200, 1'b1, 1'b0, 16'd4);
        tick();
        br_target = 32'h0000_0400;
        #1 chkAll("br_flush", 2'b11, 32'h200, 32'h200, 1'b0, 1'b1, 16'd4);
        tick();
        br_taken = 1'b0;
        #1 chkAll("br_fetch", 2'b01, 32'h200, 32'h200, 1'b1, 1'b0, 16'd4);

        // 4: trap + branch + stall -> trap wins; branch in FLUSH ignored; trap in FLUSH re-flushes
        trap = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h0000_0300;
        stall = 1'b1;
        #1 chkAll("trap_req", 2'b01, 32'h200, 32'h100, 1'b0, 1'b0, 16'd4);
        tick();
        trap = 1'b0;
        stall = 1'b0;
        br_target = 32'h0000_0500;
        #1 chkAll("trap_flush", 2'b11, 32'h100, 32'h100, 1'b0, 1'b1, 16'd4);
        tick();
        chkAll("trap_fetch", 2'b01, 32'h100, 32'h500, 1'b1, 1'b0, 16'd4);
        br_taken = 1'b0;
        trap = 1'b1;
        #1 chkAll("trap2_req", 2'b01, 32'h100, 32'h100, 1'b1, 1'b0, 16'd4);
        tick();
        chkAll("trap2_flush", 2'b11, 32'h100, 32'h100, 1'b0, 1'b1, 16'd4);
        tick();
        chkAll("flush_trap", 2'b11, 32'h100, 32'h100, 1'b0, 1'b1, 16'd4);
        trap = 1'b0;
        tick();

        // Branch + stall: branch wins; target lsbs cleared
        br_taken = 1'b1;
        br_target = 32'hFFFF_FFFE;
        stall = 1'b1;
        #1 chkAll("brstall", 2'b01, 32'h100, 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd4);
        tick();
        br_taken = 1'b0;
        stall = 1'b0;
        tick();

        // 5: wrap at top of address space, then hold under backpressure
        fetchBus.fetch_ready = 1'b1;
        #1 chkAll("wrap_req", 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 16'd4);
        tick();
        fetchBus.fetch_ready = 1'b0;
        #1 chkAll("bp0", 2'b01, 32'h0, 32'h0, 1'b1, 1'b0, 16'd5);
        tick();
        chkAll("bp1", 2'b01, 32'h0, 32'h0, 1'b1, 1'b0, 16'd5);
        tick();
        chkAll("bp2", 2'b01, 32'h0, 32'h0, 1'b1, 1'b0, 16'd5);
        fetchBus.fetch_ready = 1'b1;
        tick();
        chkAll("post_bp", 2'b01, 32'h4, 32'h8, 1'b1, 1'b0, 16'd6);

        // 6: async reset between edges, idle until start
        #3 rst_n = 1'b0;
        #1 chkAll("async_rst", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick();
        chkAll("idle_wait", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chkAll("restart", 2'b01, 32'h0, 32'h4, 1'b1, 1'b0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
